// File: rtl/sram_ctrl_ws_pkg.sv
// Shared types and constants for the wait-state SRAM controller.
// State codes, operation type and a width helper.
package sram_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_TURN   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    typedef logic [2:0] state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_ctrl_ws_if.sv
// Host and SRAM-side signal bundle for sram_ctrl_ws.
// slave = controller view, master = host plus SRAM view.
interface sram_ctrl_ws_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);

    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addrIn;
    logic [DATA_WIDTH-1:0] wdataIn;
    logic [DATA_WIDTH-1:0] rdataOut;
    logic                  done;
    logic                  busy;
    logic                  conflict;
    logic [ADDR_WIDTH-1:0] sramAddr;
    logic [DATA_WIDTH-1:0] sramDataOut;
    logic [DATA_WIDTH-1:0] sramDataIn;
    logic                  dataEnable;
    logic                  latch;
    logic                  csBar;
    logic                  oeBar;
    logic                  weBar;

    modport slave (
        input  read, write, addrIn, wdataIn, sramDataIn,
        output rdataOut, done, busy, conflict, sramAddr,
        output sramDataOut, dataEnable, latch,
        output csBar, oeBar, weBar
    );

    modport master (
        output read, write, addrIn, wdataIn, sramDataIn,
        input  rdataOut, done, busy, conflict, sramAddr,
        input  sramDataOut, dataEnable, latch,
        input  csBar, oeBar, weBar
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times ACCESS and TURN.
// Loaded with N-1, so zero marks the last cycle.
module sram_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load has priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_ws.sv
// Asynchronous-SRAM controller with wait states and turnaround.
// Outputs are registered from the next state, so they align with state.
module sram_ctrl_ws
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_WAIT  = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    sram_ctrl_ws_if.slave   bus
);

    localparam int MAXC = max3(READ_WAIT, WRITE_WAIT, TURN_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] RD_LD   = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_LD   = CW'(WRITE_WAIT - 1);
    localparam logic [CW-1:0] TURN_LD =
        CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_t state, nstate;
    op_e    op, nop;
    logic   last_rd;

    logic cs_n, oe_n, we_n, de, lat, done_q, busy_q, conf_q;
    logic n_cs, n_oe, n_we, n_de, n_lat, n_done, n_conf;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic          cap_addr, cap_wdata, cap_rdata;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;

    sram_wait_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // next state and the strobe pattern that state will present
    always_comb begin
        nstate    = state;
        nop       = op;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cap_addr  = 1'b0;
        cap_wdata = 1'b0;
        cap_rdata = 1'b0;
        n_cs      = 1'b1;
        n_oe      = 1'b1;
        n_we      = 1'b1;
        n_de      = 1'b0;
        n_lat     = 1'b0;
        n_done    = 1'b0;
        n_conf    = 1'b0;
        unique case (state)
            S_IDLE: begin
                unique case (1'b1)
                    bus.read && bus.write: begin
                        n_conf = 1'b1;
                    end
                    bus.read && !bus.write: begin
                        cap_addr = 1'b1;
                        nop      = OP_READ;
                        nstate   = S_SETUP;
                        n_cs     = 1'b0;
                        n_lat    = 1'b1;
                    end
                    bus.write && !bus.read: begin
                        cap_addr  = 1'b1;
                        cap_wdata = 1'b1;
                        nop       = OP_WRITE;
                        if (last_rd && (TURN_CYCLES > 0)) begin
                            nstate   = S_TURN;
                            cnt_load = 1'b1;
                            cnt_val  = TURN_LD;
                        end else begin
                            nstate = S_SETUP;
                            n_cs   = 1'b0;
                            n_lat  = 1'b1;
                            n_de   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_TURN: begin
                if (cnt_zero) begin
                    nstate = S_SETUP;
                    n_cs   = 1'b0;
                    n_lat  = 1'b1;
                    n_de   = (op == OP_WRITE);
                end
            end
            S_SETUP: begin
                nstate   = S_ACCESS;
                cnt_load = 1'b1;
                cnt_val  = (op == OP_READ) ? RD_LD : WR_LD;
                n_cs     = 1'b0;
                n_oe     = (op != OP_READ);
                n_we     = (op != OP_WRITE);
                n_de     = (op == OP_WRITE);
            end
            S_ACCESS: begin
                if (cnt_zero) begin
                    nstate    = S_HOLD;
                    n_done    = 1'b1;
                    n_de      = (op == OP_WRITE);
                    cap_rdata = (op == OP_READ);
                end else begin
                    n_cs = 1'b0;
                    n_oe = (op != OP_READ);
                    n_we = (op != OP_WRITE);
                    n_de = (op == OP_WRITE);
                end
            end
            S_HOLD: begin
                nstate = S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    // state, op history and registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            op      <= OP_READ;
            last_rd <= 1'b0;
            cs_n    <= 1'b1;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            de      <= 1'b0;
            lat     <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            state  <= nstate;
            op     <= nop;
            cs_n   <= n_cs;
            oe_n   <= n_oe;
            we_n   <= n_we;
            de     <= n_de;
            lat    <= n_lat;
            done_q <= n_done;
            busy_q <= (nstate != S_IDLE);
            conf_q <= n_conf;
            if (state == S_HOLD) begin
                last_rd <= (op == OP_READ);
            end
        end
    end

    // address, write data and read data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (cap_addr) begin
                addr_q <= bus.addrIn;
            end
            if (cap_wdata) begin
                wdata_q <= bus.wdataIn;
            end
            if (cap_rdata) begin
                rdata_q <= bus.sramDataIn;
            end
        end
    end

    assign bus.rdataOut    = rdata_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.conflict    = conf_q;
    assign bus.sramAddr    = addr_q;
    assign bus.sramDataOut = wdata_q;
    assign bus.dataEnable  = de;
    assign bus.latch       = lat;
    assign bus.csBar       = cs_n;
    assign bus.oeBar       = oe_n;
    assign bus.weBar       = we_n;

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Bench for sram_ctrl_ws: default and wide/slow instances.
// Vector table plus conflict and mid-write reset sequences.
module tb_sram_ctrl_ws;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic        sel     = 1'b0;
    logic        c_read  = 1'b0;
    logic        c_write = 1'b0;
    logic [15:0] c_addr  = '0;
    logic [15:0] c_wdata = '0;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem0 [2048];
    logic [15:0] mem1 [65536];

    sram_ctrl_ws_if #(.ADDR_WIDTH(11), .DATA_WIDTH(8))  if0 ();
    sram_ctrl_ws_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) if1 ();

    sram_ctrl_ws u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    sram_ctrl_ws #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .READ_WAIT  (4),
        .WRITE_WAIT (1)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    assign if0.read       = !sel && c_read;
    assign if0.write      = !sel && c_write;
    assign if0.addrIn     = c_addr[10:0];
    assign if0.wdataIn    = c_wdata[7:0];
    assign if0.sramDataIn = mem0[if0.sramAddr];

    assign if1.read       = sel && c_read;
    assign if1.write      = sel && c_write;
    assign if1.addrIn     = c_addr;
    assign if1.wdataIn    = c_wdata;
    assign if1.sramDataIn = mem1[if1.sramAddr];

    // SRAM models: store while selected, write-enabled and driven
    always @(posedge clk) begin
        if (!if0.csBar && !if0.weBar && if0.dataEnable)
            mem0[if0.sramAddr] <= if0.sramDataOut;
        if (!if1.csBar && !if1.weBar && if1.dataEnable)
            mem1[if1.sramAddr] <= if1.sramDataOut;
    end

    logic        m_lat, m_cs, m_oe, m_we, m_de;
    logic        m_done, m_busy, m_conf;
    logic [15:0] m_addr, m_rdata;

    // view of whichever instance is under test
    always_comb begin
        m_lat   = if0.latch;
        m_cs    = if0.csBar;
        m_oe    = if0.oeBar;
        m_we    = if0.weBar;
        m_de    = if0.dataEnable;
        m_done  = if0.done;
        m_busy  = if0.busy;
        m_conf  = if0.conflict;
        m_addr  = {5'b0, if0.sramAddr};
        m_rdata = {8'b0, if0.rdataOut};
        if (sel) begin
            m_lat   = if1.latch;
            m_cs    = if1.csBar;
            m_oe    = if1.oeBar;
            m_we    = if1.weBar;
            m_de    = if1.dataEnable;
            m_done  = if1.done;
            m_busy  = if1.busy;
            m_conf  = if1.conflict;
            m_addr  = if1.sramAddr;
            m_rdata = if1.rdataOut;
        end
    end

    typedef struct {
        logic        sel;
        logic        isw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          exp_done;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
        int          exp_de;
    } vec_t;

    vec_t vec [8];
    vec_t rv;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_at(input logic s,
                                           input logic [15:0] a);
        if (s) return mem1[a];
        return {8'h00, mem0[a[10:0]]};
    endfunction

    // one operation from IDLE; returns one cycle after HOLD
    task automatic run_op(input vec_t v, input int idx);
        int done_k = 0;
        int lat_k  = 0;
        int n_lat  = 0;
        int n_oe   = 0;
        int n_we   = 0;
        int n_de   = 0;
        int n_busy = 0;
        int bad    = 0;
        sel     = v.sel;
        c_addr  = v.addr;
        c_wdata = v.wdata;
        c_read  = !v.isw;
        c_write = v.isw;
        for (int k = 1; k <= 12 && done_k == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                c_read  = 1'b0;
                c_write = 1'b0;
            end
            if (m_lat) begin
                n_lat++;
                if (lat_k == 0) lat_k = k;
            end
            if (!m_oe) n_oe++;
            if (!m_we) n_we++;
            if (m_de) n_de++;
            if (m_busy) n_busy++;
            if (!m_oe && !m_we) bad++;
            if (m_de && !m_oe) bad++;
            if (lat_k == 0 && (!m_cs || m_de || !m_oe || !m_we)) bad++;
            if (m_done) done_k = k;
        end
        chk("done_cycle", idx, done_k, v.exp_done);
        chk("latch_cycle", idx, lat_k, v.exp_lat);
        chk("latch_len", idx, n_lat, 1);
        chk("oe_low", idx, n_oe, v.exp_oe);
        chk("we_low", idx, n_we, v.exp_we);
        chk("de_high", idx, n_de, v.exp_de);
        chk("busy_len", idx, n_busy, v.exp_done);
        chk("strobe_rule", idx, bad, 0);
        chk("sram_addr", idx, m_addr, v.addr);
        if (v.isw) chk("mem_data", idx, mem_at(v.sel, v.addr), v.wdata);
        else       chk("rdata", idx, m_rdata, v.exp_rd);
        @(posedge clk);
        #1;
        chk("tail_idle", idx, {m_de, m_busy, m_done, m_cs}, 4'b0001);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem0[i] <= 8'h00;
        for (int i = 0; i < 65536; i++) mem1[i] <= 16'h0000;
        mem0[11'h155] <= 8'hA5;

        vec[0] = '{1'b0, 1'b0, 16'h0155, 16'h0000, 16'h00A5, 4, 1, 2, 0, 0};
        vec[1] = '{1'b0, 1'b1, 16'h02AA, 16'h003C, 16'h0000, 5, 2, 0, 2, 4};
        vec[2] = '{1'b0, 1'b1, 16'h0101, 16'h0088, 16'h0000, 4, 1, 0, 2, 4};
        vec[3] = '{1'b0, 1'b0, 16'h02AA, 16'h0000, 16'h003C, 4, 1, 2, 0, 0};
        vec[4] = '{1'b0, 1'b1, 16'h0100, 16'h0077, 16'h0000, 5, 2, 0, 2, 4};
        vec[5] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0077, 4, 1, 2, 0, 0};
        vec[6] = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 3, 1, 0, 1, 3};
        vec[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 6, 1, 4, 0, 0};
        rv     = '{1'b0, 1'b1, 16'h02AA, 16'h0099, 16'h0000, 4, 1, 0, 2, 4};

        #12;
        chk("rst_strobes", 0, {m_cs, m_oe, m_we}, 3'b111);
        chk("rst_flags", 0, {m_de, m_lat, m_done, m_busy, m_conf}, 5'b0);
        chk("rst_addr", 0, m_addr, 16'h0);
        chk("rst_rdata", 0, m_rdata, 16'h0);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_op(vec[i], i);

        sel     = 1'b0;
        c_read  = 1'b1;
        c_write = 1'b1;
        c_addr  = 16'h0333;
        c_wdata = 16'h00EE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("conflict", i, m_conf, 1'b1);
            chk("conf_busy", i, m_busy, 1'b0);
            chk("conf_cs", i, m_cs, 1'b1);
            chk("conf_addr", i, m_addr, 16'h0100);
        end
        c_read  = 1'b0;
        c_write = 1'b0;
        @(posedge clk);
        #1;
        chk("conflict_end", 0, m_conf, 1'b0);
        chk("conf_mem", 0, mem0[11'h333], 8'h00);

        begin
            logic hit;
            hit     = 1'b0;
            c_addr  = 16'h0300;
            c_wdata = 16'h005A;
            c_write = 1'b1;
            for (int k = 1; k <= 10 && !hit; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) c_write = 1'b0;
                if (!m_we) hit = 1'b1;
            end
            chk("rst_we_seen", 0, hit, 1'b1);
        end
        #3;
        reset = 1'b0;
        #1;
        chk("arst_strobes", 0, {m_cs, m_oe, m_we}, 3'b111);
        chk("arst_flags", 0, {m_de, m_busy, m_done}, 3'b0);
        chk("arst_addr", 0, m_addr, 16'h0);
        chk("arst_rdata", 0, m_rdata, 16'h0);
        chk("arst_mem_a", 0, mem0[11'h2AA], 8'h3C);
        chk("arst_mem_b", 0, mem0[11'h155], 8'hA5);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 0, {m_busy, m_cs}, 2'b01);

        run_op(rv, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
